// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (core
// load/store path and host preload/readback port) and the DatMem macro.
interface dmem_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    // core side
    logic          run;
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdat;
    logic [DW-1:0] core_rdat;
    logic          core_stall;
    // host side
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdat;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdat;
    // memory side
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdat;
    logic          mem_wr_en;
    logic          mem_rd_en;
    logic [DW-1:0] mem_rdat;

    // arbiter view
    modport slave (
        input  run, core_req, core_we, core_addr, core_wdat,
        input  host_req, host_we, host_addr, host_wdat,
        input  mem_rdat,
        output core_rdat, core_stall,
        output host_gnt, host_rvalid, host_rdat,
        output mem_addr, mem_wdat, mem_wr_en, mem_rd_en
    );

    // environment view (core, host and DatMem together)
    modport master (
        output run, core_req, core_we, core_addr, core_wdat,
        output host_req, host_we, host_addr, host_wdat,
        output mem_rdat,
        input  core_rdat, core_stall,
        input  host_gnt, host_rvalid, host_rdat,
        input  mem_addr, mem_wdat, mem_wr_en, mem_rd_en
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port DatMem arbiter: one access per cycle, core vs host with a
// bounded host wait, read-data phases for loads and host reads.
module dmem_arbiter #(
    parameter int DW            = 8,
    parameter int AW            = 8,
    parameter int HOST_MAX_WAIT = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    dmem_arbiter_if.slave  bus
);

    localparam logic [3:0] LP_MAXW = 4'(HOST_MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CRD  = 2'd1,
        S_HRD  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_wait_cnt;
    logic [DW-1:0] r_core_rdat;
    logic [DW-1:0] r_host_rdat;

    logic w_idle;
    logic w_host_win;
    logic w_core_win;

    // Host wins when the core is halted, absent, or the host has waited long enough.
    assign w_idle     = (r_state == S_IDLE);
    assign w_host_win = w_idle && bus.host_req &&
                        (!bus.run || !bus.core_req || (r_wait_cnt >= LP_MAXW));
    assign w_core_win = w_idle && bus.core_req && bus.run && !w_host_win;

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state: reads go through a one-cycle data phase, writes stay in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_host_win && !bus.host_we)      w_next = S_HRD;
                else if (w_core_win && !bus.core_we) w_next = S_CRD;
                else                                 w_next = S_IDLE;
            end
            S_CRD:   w_next = S_IDLE;
            S_HRD:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Host wait counter: counts ungranted IDLE request cycles, saturates, holds in data phases.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wait_cnt <= 4'd0;
        end else if (w_idle) begin
            if (bus.host_req && !w_host_win) begin
                if (r_wait_cnt < LP_MAXW) r_wait_cnt <= r_wait_cnt + 4'd1;
            end else begin
                r_wait_cnt <= 4'd0;
            end
        end
    end

    // Capture read data at the end of each data phase so it stays visible afterwards.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_core_rdat <= '0;
            r_host_rdat <= '0;
        end else begin
            if (r_state == S_CRD) r_core_rdat <= bus.mem_rdat;
            if (r_state == S_HRD) r_host_rdat <= bus.mem_rdat;
        end
    end

    // Outputs: memory mux from the winner, stall/grant/rvalid; everything held at 0 in reset.
    // Read data passes straight through during its data phase so the consumer sees it
    // in the completion cycle.
    always_comb begin
        bus.mem_addr    = '0;
        bus.mem_wdat    = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_rd_en   = 1'b0;
        bus.core_stall  = 1'b0;
        bus.core_rdat   = '0;
        bus.host_gnt    = 1'b0;
        bus.host_rvalid = 1'b0;
        bus.host_rdat   = '0;
        if (!Reset) begin
            bus.core_rdat = r_core_rdat;
            bus.host_rdat = r_host_rdat;
            case (r_state)
                S_IDLE: begin
                    bus.host_gnt   = w_host_win;
                    bus.core_stall = bus.core_req && !(w_core_win && bus.core_we);
                    if (w_host_win) begin
                        bus.mem_addr  = bus.host_addr;
                        bus.mem_wr_en = bus.host_we;
                        bus.mem_rd_en = !bus.host_we;
                        if (bus.host_we) bus.mem_wdat = bus.host_wdat;
                    end else if (w_core_win) begin
                        bus.mem_addr  = bus.core_addr;
                        bus.mem_wr_en = bus.core_we;
                        bus.mem_rd_en = !bus.core_we;
                        if (bus.core_we) bus.mem_wdat = bus.core_wdat;
                    end
                end
                S_CRD: begin
                    bus.core_rdat = bus.mem_rdat;
                end
                S_HRD: begin
                    bus.core_stall  = bus.core_req;
                    bus.host_rvalid = 1'b1;
                    bus.host_rdat   = bus.mem_rdat;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios then random traffic,
// all cycles compared against a transaction-level model with its own memory image.
module tb_dmem_arbiter;

    localparam int MAXW = 4;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    dmem_arbiter_if #(.DW(8), .AW(8)) bus ();

    dmem_arbiter #(.DW(8), .AW(8), .HOST_MAX_WAIT(MAXW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // DatMem stand-in: synchronous write, registered read data.
    logic [7:0] dmem [256] = '{default: 8'h00};
    always @(posedge Clk) begin
        if (bus.mem_wr_en) dmem[bus.mem_addr] <= bus.mem_wdat;
        if (bus.mem_rd_en) bus.mem_rdat <= dmem[bus.mem_addr];
    end

    // Reference model state: what memory should hold and which read is outstanding.
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    int         m_phase;            // 0 none, 1 core load outstanding, 2 host read outstanding
    int         m_wait;
    logic [7:0] m_addr, m_crd, m_hrd;
    int         n_phase, n_wait;
    logic [7:0] n_addr, n_crd, n_hrd;
    logic       n_wr;
    logic [7:0] n_waddr, n_wdat;

    // last observed values, for scenario-level checks
    logic o_hgnt, o_stall, o_wr, o_rd, o_rv;
    logic [7:0] o_crd, o_hrd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_wait = 0; m_addr = 0; m_crd = 0; m_hrd = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".stall"}, bus.core_stall, 0);
        chk({tag, ".crdat"}, bus.core_rdat, 0);
        chk({tag, ".hgnt"},  bus.host_gnt, 0);
        chk({tag, ".rv"},    bus.host_rvalid, 0);
        chk({tag, ".hrdat"}, bus.host_rdat, 0);
        chk({tag, ".wr"},    bus.mem_wr_en, 0);
        chk({tag, ".rd"},    bus.mem_rd_en, 0);
        chk({tag, ".addr"},  bus.mem_addr, 0);
        chk({tag, ".wdat"},  bus.mem_wdat, 0);
    endtask

    // One clock: predict from the rules at the falling edge, compare, commit after the rising edge.
    task automatic cyc();
        logic hw, cw, e_gnt, e_wr, e_rd, e_stall, e_rv;
        logic [7:0] e_addr, e_wdat, e_crd, e_hrd;
        @(negedge Clk);
        hw = 0; cw = 0; e_gnt = 0; e_wr = 0; e_rd = 0; e_stall = 0; e_rv = 0;
        e_addr = 0; e_wdat = 0; e_crd = m_crd; e_hrd = m_hrd;
        n_phase = 0; n_wait = m_wait; n_addr = m_addr; n_crd = m_crd; n_hrd = m_hrd;
        n_wr = 0; n_waddr = 0; n_wdat = 0;
        if (m_phase == 0) begin
            // who owns the memory this cycle
            if (bus.host_req && (!bus.run || !bus.core_req || m_wait == MAXW)) hw = 1;
            else if (bus.core_req && bus.run) cw = 1;
            e_gnt   = hw;
            e_wr    = (hw && bus.host_we) || (cw && bus.core_we);
            e_rd    = (hw && !bus.host_we) || (cw && !bus.core_we);
            e_addr  = hw ? bus.host_addr : (cw ? bus.core_addr : 8'h00);
            e_wdat  = e_wr ? (hw ? bus.host_wdat : bus.core_wdat) : 8'h00;
            e_stall = bus.core_req && !(cw && bus.core_we);
            if (e_rd) begin n_phase = hw ? 2 : 1; n_addr = e_addr; end
            if (e_wr) begin n_wr = 1; n_waddr = e_addr; n_wdat = e_wdat; end
            n_wait = (bus.host_req && !hw) ? ((m_wait < MAXW) ? m_wait + 1 : MAXW) : 0;
        end else if (m_phase == 1) begin
            e_crd = ref_mem[m_addr];
            n_crd = e_crd;
        end else begin
            e_stall = bus.core_req;
            e_rv    = 1;
            e_hrd   = ref_mem[m_addr];
            n_hrd   = e_hrd;
        end
        o_hgnt = bus.host_gnt; o_stall = bus.core_stall; o_wr = bus.mem_wr_en;
        o_rd = bus.mem_rd_en; o_rv = bus.host_rvalid; o_crd = bus.core_rdat; o_hrd = bus.host_rdat;
        chk("gnt",   bus.host_gnt, e_gnt);
        chk("stall", bus.core_stall, e_stall);
        chk("wr_en", bus.mem_wr_en, e_wr);
        chk("rd_en", bus.mem_rd_en, e_rd);
        chk("addr",  bus.mem_addr, e_addr);
        if (!e_rd) chk("wdat", bus.mem_wdat, e_wdat);
        chk("rvalid", bus.host_rvalid, e_rv);
        chk("crdat", bus.core_rdat, e_crd);
        if (e_rv || m_phase == 0) chk("hrdat", bus.host_rdat, e_hrd);
        @(posedge Clk);
        #1;
        if (n_wr) ref_mem[n_waddr] = n_wdat;
        m_phase = n_phase; m_wait = n_wait; m_addr = n_addr; m_crd = n_crd; m_hrd = n_hrd;
    endtask

    task automatic drive(input logic run, input logic creq, input logic cwe,
                         input logic [7:0] caddr, input logic [7:0] cwdat,
                         input logic hreq, input logic hwe,
                         input logic [7:0] haddr, input logic [7:0] hwdat);
        bus.run = run; bus.core_req = creq; bus.core_we = cwe;
        bus.core_addr = caddr; bus.core_wdat = cwdat;
        bus.host_req = hreq; bus.host_we = hwe; bus.host_addr = haddr; bus.host_wdat = hwdat;
        cyc();
    endtask

    initial begin
        int n;
        model_reset();
        bus.run = 0; bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdat = 0;
        bus.host_req = 0; bus.host_we = 0; bus.host_addr = 0; bus.host_wdat = 0;
        bus.mem_rdat = 0;

        // reset state, with requests present to show outputs are forced low
        bus.core_req = 1; bus.host_req = 1; bus.run = 1;
        #12;
        chk_all_zero("rst");
        @(posedge Clk); #1;
        Reset = 0;

        // core store then load
        drive(1, 1, 1, 8'h10, 8'hA5, 0, 0, 0, 0);
        chk("st.nostall", o_stall, 0);
        chk("st.wr", o_wr, 1);
        drive(1, 1, 0, 8'h10, 8'h00, 0, 0, 0, 0);
        chk("ld.stall", o_stall, 1);
        drive(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
        chk("ld.nostall", o_stall, 0);
        chk("ld.rdat", o_crd, 8'hA5);

        // host preload with the core halted
        drive(0, 0, 0, 0, 0, 1, 1, 8'h20, 8'h3C);
        chk("hw.gnt", o_hgnt, 1);
        drive(0, 0, 0, 0, 0, 1, 0, 8'h20, 8'h00);
        chk("hr.gnt", o_hgnt, 1);
        chk("hr.rv0", o_rv, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("hr.rv1", o_rv, 1);
        chk("hr.rdat", o_hrd, 8'h3C);

        // contention: core stores every cycle, host read held until granted
        n = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 1, 8'(8'h40 + i), 8'($urandom), 1, 0, 8'h20, 8'h00);
            if (o_hgnt) break;
            n++;
        end
        chk("cont.core_grants", n, MAXW);
        chk("cont.stall_at_gnt", o_stall, 1);
        drive(1, 1, 1, 8'h50, 8'h11, 0, 0, 0, 0);
        chk("cont.hrd_stall", o_stall, 1);
        chk("cont.rdat", o_hrd, 8'h3C);

        // core load and host write in the same cycle with no prior wait
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 8'h10, 8'h00, 1, 1, 8'h30, 8'h55);
        chk("lvh.core_first", o_hgnt, 0);
        chk("lvh.rd", o_rd, 1);
        drive(1, 0, 0, 0, 0, 1, 1, 8'h30, 8'h55);
        chk("lvh.crd_nognt", o_hgnt, 0);
        chk("lvh.crd_rdat", o_crd, 8'hA5);
        drive(1, 0, 0, 0, 0, 1, 1, 8'h30, 8'h55);
        chk("lvh.host_next", o_hgnt, 1);

        // halt: host wins every time, core stalled throughout
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 1, 8'h60, 8'h77, 1, 1, 8'(8'h70 + i), 8'(i));
            chk("halt.gnt", o_hgnt, 1);
            chk("halt.stall", o_stall, 1);
        end

        // reset asserted during a host read data phase
        drive(0, 0, 0, 0, 0, 1, 0, 8'h20, 8'h00);
        Reset = 1;
        #1;
        chk_all_zero("rst_hrd");
        @(negedge Clk);
        chk("rst_hrd.rv", bus.host_rvalid, 0);
        @(posedge Clk); #1;
        Reset = 0;
        model_reset();
        bus.host_req = 0;

        // random traffic over a small address window to get read-after-write hits
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 7) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  8'($urandom_range(0, 15)), 8'($urandom),
                  ($urandom_range(0, 2) != 0), $urandom_range(0, 1),
                  8'($urandom_range(0, 15)), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter and access sequencer: shares `DatMem` between the core's load/store path (`Ldr`/`Str` from `Ctrl`) and an external host port used for program-data preload and result readback. It sits between `Ctrl`/`RegFile` and `DatMem`. It issues at most one memory access per cycle. It stalls the core while a load completes or while the host holds the port, and it guarantees the host a bounded wait.

## Interface
Parameters:
- `DW`, 8: data width.
- `AW`, 8: address width.
- `HOST_MAX_WAIT`, 4: host request-pending cycles after which the host beats the core (1..15).

Ports:
- `Clk`  in  1  clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  core running; 0 = core halted, host has absolute priority.
- `core_req`  in  1  core access this cycle (`Ldr | Str`).
- `core_we`  in  1  1 = store, 0 = load.
- `core_addr`  in  AW  core address.
- `core_wdat`  in  DW  core store data.
- `core_rdat`  out  DW  load data, valid when load completes.
- `core_stall`  out  1  freeze PC/regfile write this cycle.
- `host_req`  in  1  host access request, held until `host_gnt`.
- `host_we`  in  1  1 = write, 0 = read.
- `host_addr`  in  AW  host address.
- `host_wdat`  in  DW  host write data.
- `host_gnt`  out  1  one-cycle accept pulse.
- `host_rvalid`  out  1  one-cycle read-data-valid pulse.
- `host_rdat`  out  DW  host read data.
- `mem_addr`  out  AW  to `DatMem` `addr`.
- `mem_wdat`  out  DW  to `DatMem` write data.
- `mem_wr_en`  out  1  to `DatMem` `wr_en`.
- `mem_rd_en`  out  1  to `DatMem` `rd_en`.
- `mem_rdat`  in  DW  from `DatMem`, valid the cycle after `mem_rd_en`.

## Operation
- States: `IDLE`, `CRD` (core read-data phase), `HRD` (host read-data phase). No new access is issued in `CRD`/`HRD`.
- Grant in `IDLE`:
  - Only one requester: that requester wins.
  - Both requesting, `run=1`, `wait_cnt < HOST_MAX_WAIT`: core wins.
  - Both requesting, `wait_cnt == HOST_MAX_WAIT`: host wins.
  - `run=0`: host wins whenever requesting. The core is never granted while `run=0`.
- Granted write: `mem_wr_en=1`, address and data muxed from the winner, completes the same cycle, state stays `IDLE`.
- Granted read: `mem_rd_en=1`. Next state is `CRD` or `HRD`.
  - `CRD`: capture `mem_rdat` into `core_rdat`, `core_stall=0`, return to `IDLE`.
  - `HRD`: capture `mem_rdat` into `host_rdat`, pulse `host_rvalid`, return to `IDLE`.
- `core_stall=1` when:
  - in `IDLE` with `core_req=1`, and either the core is not granted or the grant is a load, or
  - in `HRD` with `core_req=1`.
- `core_stall=0` when `core_req=0`, on a granted store, and in `CRD`.
- `host_gnt=1` only in the `IDLE` cycle the host wins.
- `wait_cnt` (4 bit):
  - increments, saturating at `HOST_MAX_WAIT`, each `IDLE` cycle with `host_req=1` and no host grant;
  - clears on host grant or `host_req=0`;
  - holds in `CRD`/`HRD`.
- Idle memory outputs: `mem_wr_en=mem_rd_en=0`, `mem_addr`/`mem_wdat` = 0.

## Timing
- Reset values: state `IDLE`, `wait_cnt=0`, `core_rdat=0`, `host_rdat=0`, `host_gnt=0`, `host_rvalid=0`, `mem_wr_en=0`, `mem_rd_en=0`, `core_stall=0`. While `Reset=1` all outputs are 0.
- Latency:
  - Uncontended store: 1 cycle, no stall.
  - Load: 2 cycles (1 stall cycle).
  - Host read: `host_gnt` at cycle N, `host_rvalid` at N+1.
- Worst-case host wait with `run=1` and continuous core traffic: `HOST_MAX_WAIT` cycles of core grants plus any in-flight `CRD`, then grant.
- `Reset` asserted mid-read (`CRD`/`HRD`): access dropped, no `host_rvalid`, `core_rdat` cleared.
- Host deasserting `host_req` before grant: legal, no access, `wait_cnt` clears.
- `run` falling while the core is stalled in `IDLE`: host wins the next grant; the core remains stalled.

## Test plan
- Reset: assert `Reset` asynchronously in `HRD` -> `host_rvalid` never pulses, all outputs 0 immediately.
- Core store/load: store 0xA5 to addr 0x10 (no stall), then load 0x10 -> `core_stall` high 1 cycle, `core_rdat=0xA5` in the next cycle.
- Host preload: `run=0`, host writes 0x3C to 0x20 then reads 0x20 -> `host_gnt` each accept, `host_rvalid` with `host_rdat=0x3C` one cycle after the read grant.
- Contention: `run=1`, `HOST_MAX_WAIT=4`, core stores every cycle, host read requested -> 4 core grants, host granted on the 5th cycle, core stalled that cycle.
- Load vs host: core load and host write arrive in the same cycle with `wait_cnt=0` -> core granted, `CRD`, host granted in the following `IDLE` cycle.
- Halt: `run=0` with both requesting -> host granted every time, core stalled throughout.
